// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory req/ack access with stall,
// MEM/WB register, branch resolution and MEM-stage forwarding outputs.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  in_wb,
    input  logic [2:0]  in_mem,
    input  logic [31:0] in_pc_jump,
    input  logic [31:0] in_alu_result,
    input  logic        in_alu_zero,
    input  logic [31:0] in_reg_b,
    input  logic [4:0]  in_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic [4:0]  fwd_rd,
    output logic        fwd_reg_wr,
    output logic [31:0] fwd_alu_result,
    output logic [1:0]  out_wb,
    output logic [31:0] out_read_data,
    output logic [31:0] out_alu_result,
    output logic [4:0]  out_rd,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]       state, stateNext;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic             access, misaligned, timeoutHit;
    logic             reqNext, weNext, misNext, busErrNext;
    logic [31:0]      addrNext, wdataNext, readNext, aluNext;
    logic [1:0]       wbNext;
    logic [4:0]       rdNext;

    assign access     = in_mem[1] | in_mem[0];
    assign misaligned = access & (in_alu_result[1:0] != 2'b00);
    assign timeoutHit = (state == ACCESS) & ~dmem_ack & (waitCnt == CNT_W'(TIMEOUT - 1));

    // Forwarding and branch outputs follow the EX/MEM register directly
    assign pc_src         = in_mem[2] & in_alu_zero;
    assign pc_branch      = in_pc_jump;
    assign fwd_rd         = in_rd;
    assign fwd_reg_wr     = in_wb[1] & ~misaligned;
    assign fwd_alu_result = in_alu_result;
    assign stall          = (state == IDLE) ? (access & ~misaligned) : (~dmem_ack & ~timeoutHit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            waitCnt        <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            out_wb         <= 2'b00;
            out_read_data  <= '0;
            out_alu_result <= '0;
            out_rd         <= '0;
            misalign_err   <= 1'b0;
            bus_err        <= 1'b0;
        end else begin
            state          <= stateNext;
            waitCnt        <= waitCntNext;
            dmem_req       <= reqNext;
            dmem_we        <= weNext;
            dmem_addr      <= addrNext;
            dmem_wdata     <= wdataNext;
            out_wb         <= wbNext;
            out_read_data  <= readNext;
            out_alu_result <= aluNext;
            out_rd         <= rdNext;
            misalign_err   <= misNext;
            bus_err        <= busErrNext;
        end
    end

    // Next-state and registered-output logic; MEM/WB defaults to a bubble
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        reqNext     = dmem_req;
        weNext      = dmem_we;
        addrNext    = dmem_addr;
        wdataNext   = dmem_wdata;
        wbNext      = 2'b00;
        readNext    = '0;
        aluNext     = '0;
        rdNext      = '0;
        misNext     = 1'b0;
        busErrNext  = bus_err;
        case (state)
            IDLE: begin
                if (misaligned) begin
                    misNext = 1'b1;
                    aluNext = in_alu_result;
                    rdNext  = in_rd;
                end else if (access) begin
                    stateNext   = ACCESS;
                    waitCntNext = '0;
                    reqNext     = 1'b1;
                    weNext      = in_mem[0];
                    addrNext    = {in_alu_result[31:2], 2'b00};
                    wdataNext   = in_reg_b;
                end else begin
                    wbNext  = in_wb;
                    aluNext = in_alu_result;
                    rdNext  = in_rd;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    stateNext = IDLE;
                    reqNext   = 1'b0;
                    wbNext    = in_wb;
                    readNext  = dmem_we ? 32'd0 : dmem_rdata;
                    aluNext   = in_alu_result;
                    rdNext    = in_rd;
                end else if (timeoutHit) begin
                    stateNext  = IDLE;
                    reqNext    = 1'b0;
                    busErrNext = 1'b1;
                    aluNext    = in_alu_result;
                    rdNext     = in_rd;
                end else begin
                    waitCntNext = waitCnt + CNT_W'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of non-memory vectors plus
// hand sequences for load, store, timeout and reset-during-access.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_wb;
    logic [2:0]  in_mem;
    logic [31:0] in_pc_jump, in_alu_result, in_reg_b;
    logic        in_alu_zero;
    logic [4:0]  in_rd;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, pc_src, fwd_reg_wr, misalign_err, bus_err;
    logic [31:0] pc_branch, fwd_alu_result, out_read_data, out_alu_result;
    logic [4:0]  fwd_rd, out_rd;
    logic [1:0]  out_wb;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_wb(in_wb), .in_mem(in_mem), .in_pc_jump(in_pc_jump),
        .in_alu_result(in_alu_result), .in_alu_zero(in_alu_zero),
        .in_reg_b(in_reg_b), .in_rd(in_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .pc_src(pc_src), .pc_branch(pc_branch),
        .fwd_rd(fwd_rd), .fwd_reg_wr(fwd_reg_wr), .fwd_alu_result(fwd_alu_result),
        .out_wb(out_wb), .out_read_data(out_read_data),
        .out_alu_result(out_alu_result), .out_rd(out_rd),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [31:0] alu;
        logic [31:0] regB;
        logic [4:0]  rd;
        logic        zero;
        logic [31:0] pcJ;
        logic [1:0]  eWb;
        logic        eMis;
        logic        eFwdWr;
        logic        ePcSrc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [31:0] alu,
                         input logic [31:0] regB, input logic [4:0] rd);
        in_wb = wb; in_mem = mem; in_alu_result = alu; in_reg_b = regB; in_rd = rd;
        in_alu_zero = 1'b0; in_pc_jump = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stallCnt;
        int reqCnt;
        int guard;
        logic abortStall;

        vecs[0] = '{2'b10, 3'b000, 32'h2A,       32'h0,  5'd5,  1'b0, 32'h0,  2'b10, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'b00, 3'b100, 32'h0,        32'h0,  5'd0,  1'b1, 32'h40, 2'b00, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{2'b00, 3'b100, 32'h8,        32'h0,  5'd0,  1'b0, 32'h80, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 3'b010, 32'h13,       32'h0,  5'd7,  1'b0, 32'h0,  2'b00, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'b00, 3'b001, 32'h22,       32'h55, 5'd0,  1'b0, 32'h0,  2'b00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b10, 3'b000, 32'h13,       32'h0,  5'd12, 1'b1, 32'h0,  2'b10, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{2'b11, 3'b000, 32'hFFFFFFFF, 32'h0,  5'd31, 1'b0, 32'h0,  2'b11, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 3'b100, 32'h0,        32'h0,  5'd1,  1'b1, 32'hC0, 2'b10, 1'b0, 1'b1, 1'b1};

        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        drive(2'b00, 3'b000, 32'd0, 32'd0, 5'd0);
        #12;
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_out_wb", 32'(out_wb), 32'd0);
        check("rst_out_alu", out_alu_result, 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Non-memory / misaligned vectors
        for (int i = 0; i < 8; i++) begin
            in_wb = vecs[i].wb; in_mem = vecs[i].mem; in_alu_result = vecs[i].alu;
            in_reg_b = vecs[i].regB; in_rd = vecs[i].rd; in_alu_zero = vecs[i].zero;
            in_pc_jump = vecs[i].pcJ;
            #1;
            check($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            check($sformatf("v%0d_pc_src", i), 32'(pc_src), 32'(vecs[i].ePcSrc));
            check($sformatf("v%0d_pc_branch", i), pc_branch, vecs[i].pcJ);
            check($sformatf("v%0d_fwd_wr", i), 32'(fwd_reg_wr), 32'(vecs[i].eFwdWr));
            check($sformatf("v%0d_fwd_rd", i), 32'(fwd_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d_fwd_alu", i), fwd_alu_result, vecs[i].alu);
            tick();
            check($sformatf("v%0d_req", i), 32'(dmem_req), 32'd0);
            check($sformatf("v%0d_out_wb", i), 32'(out_wb), 32'(vecs[i].eWb));
            check($sformatf("v%0d_out_alu", i), out_alu_result, vecs[i].alu);
            check($sformatf("v%0d_out_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d_out_rdata", i), out_read_data, 32'd0);
            check($sformatf("v%0d_misalign", i), 32'(misalign_err), 32'(vecs[i].eMis));
        end

        // Load at 0x10, ack on the fourth ACCESS cycle
        drive(2'b11, 3'b010, 32'h10, 32'h0, 5'd9);
        stallCnt = 0;
        #1;
        check("ld_idle_stall", 32'(stall), 32'd1);
        if (stall) stallCnt++;
        tick();
        check("ld_req", 32'(dmem_req), 32'd1);
        check("ld_we", 32'(dmem_we), 32'd0);
        check("ld_addr", dmem_addr, 32'h10);
        check("ld_bubble", 32'(out_wb), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (stall) stallCnt++;
            tick();
            check("ld_wait_req", 32'(dmem_req), 32'd1);
            check("ld_wait_bubble", 32'(out_wb), 32'd0);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld_ack_stall", 32'(stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        check("ld_stall_cycles", 32'(stallCnt), 32'd4);
        check("ld_req_drop", 32'(dmem_req), 32'd0);
        check("ld_out_wb", 32'(out_wb), 32'b11);
        check("ld_rdata", out_read_data, 32'hDEADBEEF);
        check("ld_out_rd", 32'(out_rd), 32'd9);
        tick();
        check("ld_single_wb", 32'(out_wb), 32'd0);

        // Store at 0x20, immediate ack
        drive(2'b00, 3'b001, 32'h20, 32'h1234, 5'd0);
        #1;
        check("st_idle_stall", 32'(stall), 32'd1);
        tick();
        check("st_req", 32'(dmem_req), 32'd1);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_wdata", dmem_wdata, 32'h1234);
        check("st_addr", dmem_addr, 32'h20);
        check("st_bubble", 32'(out_wb), 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF0000;
        #1;
        check("st_ack_stall", 32'(stall), 32'd0);
        tick();
        dmem_ack = 1'b0;
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        check("st_req_drop", 32'(dmem_req), 32'd0);
        check("st_rdata_zero", out_read_data, 32'd0);
        check("st_bus_err", 32'(bus_err), 32'd0);
        tick();

        // Load with no ack: aborts after 16 ACCESS cycles
        drive(2'b11, 3'b010, 32'h30, 32'h0, 5'd3);
        tick();
        reqCnt = 0; guard = 0; abortStall = 1'b1;
        while (dmem_req && guard < 40) begin
            reqCnt++;
            #1;
            abortStall = stall;
            tick();
            guard++;
        end
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        check("to_req_cycles", 32'(reqCnt), 32'd16);
        check("to_abort_stall", 32'(abortStall), 32'd0);
        check("to_bus_err", 32'(bus_err), 32'd1);
        check("to_out_wb", 32'(out_wb), 32'd0);
        check("to_rdata", out_read_data, 32'd0);
        check("to_out_alu", out_alu_result, 32'h30);
        tick();
        tick();
        check("to_bus_err_sticky", 32'(bus_err), 32'd1);
        check("to_req_idle", 32'(dmem_req), 32'd0);

        // Reset while an access is in flight, late ack ignored
        drive(2'b11, 3'b010, 32'h40, 32'h0, 5'd4);
        tick();
        check("rs_req", 32'(dmem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rs_req_async", 32'(dmem_req), 32'd0);
        check("rs_bus_err_clr", 32'(bus_err), 32'd0);
        drive(2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ack = 1'b0;
        check("rs_late_ack_req", 32'(dmem_req), 32'd0);
        check("rs_late_ack_rdata", out_read_data, 32'd0);
        check("rs_late_ack_wb", 32'(out_wb), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
